// File: rtl/tdm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_pkg : shared types and constants for the TDM demultiplexer     |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package tdm_pkg;

  localparam int         N_CH       = 4;
  localparam logic [7:0] ERRCNT_MAX = 8'hFF;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_slot_ctr : frame slot counter with load-to-1, increment, wrap  |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int N     = N_CH,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load1,
  input  logic             inc,
  output logic [SEL_W-1:0] slot,
  output logic             last
);

  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SEL_W'(1);
    end else if (inc) begin
      slot <= last ? '0 : slot + SEL_W'(1);
    end
  end

  assign last = (slot == C_LAST);

endmodule
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_demux4 : 4-slot TDM demultiplexer with sync-marker alignment   |
// | Optional error counter: define TDM_DEMUX_ERRCNT_EN                 |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = N_CH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y [N],
  output logic             frame_valid,
  output logic             frame_err,
  output logic             locked
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  input  logic             err_clr,
  output logic [7:0]       err_count
`endif
);

  localparam int SEL_W = $clog2(N);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   w_slot;
  logic               w_last;
  logic               w_load1;
  logic               w_inc;
  logic               w_sh_we;
  logic [SEL_W-1:0]   w_sh_idx;
  logic               w_done;
  logic               w_err;
  logic [WIDTH-1:0]   r_sh [N-1];

  tdm_slot_ctr #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load1 (w_load1),
    .inc   (w_inc),
    .slot  (w_slot),
    .last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load1     = 1'b0;
    w_inc       = 1'b0;
    w_sh_we     = 1'b0;
    w_sh_idx    = w_slot;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (sync) begin
            w_load1     = 1'b1;
            w_sh_we     = 1'b1;
            w_sh_idx    = '0;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          // A sync always restarts the frame; it is only an error when mid-frame.
          if (sync) begin
            w_err    = (w_slot != '0);
            w_load1  = 1'b1;
            w_sh_we  = 1'b1;
            w_sh_idx = '0;
          end else if (w_slot == '0) begin
            w_err       = 1'b1;
            w_state_nxt = HUNT;
          end else if (w_last) begin
            w_done = 1'b1;
            w_inc  = 1'b1;
          end else begin
            w_sh_we = 1'b1;
            w_inc   = 1'b1;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      for (int k = 0; k < N - 1; k++) r_sh[k] <= '0;
      for (int k = 0; k < N; k++)     y[k]    <= '0;
    end else begin
      frame_valid <= w_done;
      frame_err   <= w_err;
      for (int k = 0; k < N - 1; k++) begin
        if (w_sh_we && (w_sh_idx == SEL_W'(k))) r_sh[k] <= din;
      end
      // The last slot goes straight to y so the whole frame lands on one edge.
      if (w_done) begin
        for (int k = 0; k < N - 1; k++) y[k] <= r_sh[k];
        y[N-1] <= din;
      end
    end
  end

  assign locked = (r_state == LOCKED);

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (w_err && (r_err_count != ERRCNT_MAX)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tdm_demux4 : directed self-checking bench for tdm_demux4        |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       sync;
  logic [7:0] y [4];
  logic       frame_valid;
  logic       frame_err;
  logic       locked;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic       err_clr;
  logic [7:0] err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int fv_cnt   = 0;
  int fe_cnt   = 0;
  int f0, e0;

  tdm_demux4 #(
    .WIDTH (8),
    .N     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .y           (y),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .locked      (locked)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_clr     (err_clr),
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are counted at the edge that ends the cycle in which they were visible.
  always @(posedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err)   fe_cnt++;
  end

  function automatic logic [31:0] yv();
    return {y[0], y[1], y[2], y[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic s, input logic [7:0] d);
    din_valid = 1'b1;
    sync      = s;
    din       = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    sync      = 1'b0;
`ifdef TDM_DEMUX_ERRCNT_EN
    err_clr   = 1'b0;
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_y",      yv(),        32'h0);
    check("rst_fv",     frame_valid, 1'b0);
    check("rst_fe",     frame_err,   1'b0);
    check("rst_locked", locked,      1'b0);
    rst_n = 1'b1;
    idle(1);

    // Unsynchronised samples in HUNT are dropped
    f0 = fv_cnt; e0 = fe_cnt;
    send(1'b0, 8'hAA);
    send(1'b0, 8'hBB);
    check("hunt_locked", locked, 1'b0);
    idle(1);
    check("hunt_y",  yv(),        32'h0);
    check("hunt_fv", fv_cnt - f0, 0);
    check("hunt_fe", fe_cnt - e0, 0);

    // First aligned frame
    send(1'b1, 8'h01);
    check("lock_rise", locked, 1'b1);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    check("f1_partial_y", yv(), 32'h0);
    send(1'b0, 8'h04);
    check("f1_fv", frame_valid, 1'b1);
    check("f1_y",  yv(),        32'h01020304);
    idle(1);
    check("f1_fv_fall", frame_valid, 1'b0);

    // Two back-to-back frames with din_valid held high
    f0 = fv_cnt;
    send(1'b1, 8'h11);
    send(1'b0, 8'h22);
    send(1'b0, 8'h33);
    send(1'b0, 8'h44);
    check("f2_y",  yv(),        32'h11223344);
    check("f2_fv", frame_valid, 1'b1);
    send(1'b1, 8'hA1);
    check("b2b_fv_gap", frame_valid, 1'b0);
    send(1'b0, 8'hA2);
    send(1'b0, 8'hA3);
    send(1'b0, 8'hA4);
    check("b2b_y", yv(), 32'hA1A2A3A4);
    idle(1);
    check("b2b_fv_cnt", fv_cnt - f0, 2);
    check("b2b_locked", locked, 1'b1);

    // Early sync: partial frame discarded, new frame kept
    f0 = fv_cnt; e0 = fe_cnt;
    send(1'b1, 8'h10);
    send(1'b0, 8'h20);
    send(1'b1, 8'h50);
    check("resync_fe",     frame_err, 1'b1);
    check("resync_locked", locked,    1'b1);
    check("resync_y_hold", yv(),      32'hA1A2A3A4);
    send(1'b0, 8'h60);
    check("resync_fe_fall", frame_err, 1'b0);
    send(1'b0, 8'h70);
    send(1'b0, 8'h80);
    check("resync_y",  yv(),        32'h50607080);
    check("resync_fv", frame_valid, 1'b1);
    idle(1);
    check("resync_fv_cnt", fv_cnt - f0, 1);
    check("resync_fe_cnt", fe_cnt - e0, 1);

    // Missing sync at slot 0
    send(1'b0, 8'h99);
    check("nosync_fe",     frame_err, 1'b1);
    check("nosync_fv",     frame_valid, 1'b0);
    check("nosync_locked", locked,    1'b0);
    check("nosync_y",      yv(),      32'h50607080);
    idle(1);

    // Frame with gaps of 0..3 idle cycles between samples
    f0 = fv_cnt; e0 = fe_cnt;
    send(1'b1, 8'h05);
    send(1'b0, 8'h06);
    idle(1);
    send(1'b0, 8'h07);
    idle(2);
    check("gap_y_hold", yv(), 32'h50607080);
    send(1'b0, 8'h08);
    check("gap_fv", frame_valid, 1'b1);
    idle(3);
    check("gap_y",      yv(),        32'h05060708);
    check("gap_fv_cnt", fv_cnt - f0, 1);
    check("gap_fe_cnt", fe_cnt - e0, 0);

    // Asynchronous reset mid-frame
    send(1'b1, 8'hC1);
    send(1'b0, 8'hC2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y",      yv(),   32'h0);
    check("arst_locked", locked, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = fv_cnt;
    send(1'b0, 8'hD1);
    send(1'b0, 8'hD2);
    send(1'b0, 8'hD3);
    send(1'b0, 8'hD4);
    idle(1);
    check("post_rst_y",  yv(),        32'h0);
    check("post_rst_fv", fv_cnt - f0, 0);
    check("post_rst_lk", locked,      1'b0);

`ifdef TDM_DEMUX_ERRCNT_EN
    check("ec_rst", err_count, 8'd0);
    send(1'b1, 8'h5A);
    for (int i = 0; i < 300; i++) send(1'b1, 8'h5A);
    idle(1);
    check("ec_sat", err_count, 8'd255);
    send(1'b1, 8'h00);
    send(1'b1, 8'h00);
    check("ec_hold", err_count, 8'd255);
    err_clr = 1'b1;
    send(1'b1, 8'h00);
    err_clr = 1'b0;
    check("ec_clr_vs_err", err_count, 8'd0);
    send(1'b1, 8'h00);
    check("ec_inc", err_count, 8'd1);
    idle(1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division demultiplexer: the receive end of the 4-to-1 select path. Takes a serial stream of samples that a 4-to-1 multiplexer emits one slot per valid cycle, recovers slot alignment from a sync marker, and presents all four channels as one coherent, registered frame. Sits downstream of the mux/serialiser and feeds per-channel logic that needs all four values updated together.

## Interface

- WIDTH, 8, sample width in bits
- N, 4, channels per frame (fixed at 4; SEL_W = $clog2(N) = 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  serial sample
- din_valid  input  1  din is a valid sample this cycle
- sync  input  1  marks din as slot 0 of a frame; qualified by din_valid
- y  output  N x WIDTH  unpacked array; y[k] is the channel-k value of the last complete frame
- frame_valid  output  1  one-cycle pulse: y updated with a new frame
- frame_err  output  1  one-cycle pulse: alignment error detected
- locked  output  1  high in state LOCKED

## Operation

- States: HUNT (no alignment), LOCKED.
- Slot counter slot (SEL_W bits); shadow registers sh[0..N-2] hold slots 0..N-2 of the frame in progress.
- An accepted sample is one with din_valid=1. With din_valid=0, sync, din and slot are ignored and nothing changes.
- HUNT:
  - An accepted sample without sync is discarded.
  - An accepted sample with sync is written to sh[0], slot becomes 1, and the state goes to LOCKED.
- LOCKED, accepted sample:
  - slot=0 with sync: write sh[0], slot becomes 1.
  - slot=0 without sync: frame_err pulses, the sample is discarded, and the state goes to HUNT.
  - slot in 1..N-2 without sync: write sh[slot], slot increments.
  - slot=N-1 without sync: y[0..N-2] load from sh, y[N-1] loads din, frame_valid pulses, and slot wraps to 0.
  - slot≠0 with sync: frame_err pulses and the partial frame is discarded (y unchanged). The sample is written to sh[0], slot becomes 1, and the state stays LOCKED.
- y changes only on a complete frame, all N channels on the same edge. Partial frames never appear on y.
- frame_valid and frame_err are mutually exclusive.

## Timing

- All outputs are registered.
- Reset values: y all zero, frame_valid=0, frame_err=0, locked=0, state HUNT, slot=0, shadow registers zero.
- Reset applies asynchronously on rst_n fall. Release is synchronous to clk.
- Reset mid-frame discards the partial frame. The first frame after reset requires sync.
- Latency: y and frame_valid update on the clk edge that accepts slot N-1. They are visible in the following cycle, one cycle after the last sample is presented.
- frame_err is visible in the cycle after the offending sample.
- locked rises in the cycle after the first sync is accepted. It falls in the cycle after a missing-sync error.
- Back-to-back frames: din_valid may be held high continuously, giving a frame_valid pulse every N cycles. Gaps (din_valid=0) may occur at any slot and do not break alignment.

## Configuration

- TDM_DEMUX_ERRCNT_EN defined:
  - Adds output err_count, 8 bits, reset 0.
  - It increments on every frame_err pulse and saturates at 255.
  - Input err_clr (1 bit, synchronous) clears it to 0. If err_clr coincides with an error, the result is 0.
- TDM_DEMUX_ERRCNT_EN undefined: err_count and err_clr ports do not exist and no counter logic is built.

## Structure

- Package tdm_pkg:
  - typedef state_t enum {HUNT, LOCKED}.
  - localparam N_CH = 4.
  - Saturation limit constant ERRCNT_MAX = 8'hFF.
- The module parameter N defaults to tdm_pkg::N_CH.
- One sub-module: tdm_slot_ctr, the slot counter with load-to-1, increment, and wrap. It outputs slot and last (slot==N-1).
- FSM, shadow registers, and output registers stay in tdm_demux4.

## Test plan

- Reset, then the stream {sync:8'h11, 8'h22, 8'h33, 8'h44} with din_valid held high -> y={11,22,33,44}, one frame_valid pulse one cycle after 8'h44, locked=1.
- 8'hAA, 8'hBB without sync while in HUNT -> discarded, y stays zero, no pulses. Then a sync frame {1,2,3,4} -> y={1,2,3,4}.
- Locked. Send sync:8'h10, 8'h20, then sync:8'h50, 8'h60, 8'h70, 8'h80 -> frame_err once, y={50,60,70,80}, no frame_valid for the partial frame.
- After a good frame, send 8'h99 at slot 0 without sync -> frame_err, locked=0, y unchanged.
- Frame {5,6,7,8} with din_valid=0 gaps of 0–3 cycles between samples -> y={5,6,7,8}, exactly one frame_valid. rst_n pulsed low after two samples of a following frame -> y=0, locked=0 immediately.
- With TDM_DEMUX_ERRCNT_EN: 300 forced errors -> err_count=255; err_clr -> 0.
